obuf_pingpong: RTL and testbench
================================

Name: obuf_pingpong

Overview:
- Banked, double-buffered output buffer directly downstream of the matrix array; consumes the array's per-bank write port and the controller's tile-finish pulse.
- Array writes one tile into the "write half" while a downstream reader (vector stage) drains the previously committed tile from the "read half".
- Tile commit and release are token handshakes. Full and empty status back-pressure the matrix controller and the reader respectively.

Parameters:
- OBufBank, 4, number of independent banks.
- OBufDepth, 64, entries per bank per half.
- OBufWidth, 128, bits per entry.
- OBufAddrW, $clog2(OBufDepth), per-half address width (derived, not overridden).

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- wAddr  input  [OBufBank-1:0][OBufAddrW-1:0]  per-bank write address within the write half.
- wData  input  [OBufBank-1:0][OBufWidth-1:0]  per-bank write data.
- wEn  input  [OBufBank-1:0]  per-bank write enable.
- tileDone  input  1  one-cycle pulse from the matrix controller (mOutTileFinish); commits the write half.
- rAddr  input  [OBufBank-1:0][OBufAddrW-1:0]  per-bank read address within the read half.
- rEn  input  [OBufBank-1:0]  per-bank read enable.
- rRelease  input  1  one-cycle pulse from the reader; frees the read half.
- rData  output  [OBufBank-1:0][OBufWidth-1:0]  per-bank read data, 1-cycle latency.
- wFull  output  1  both halves committed; the array must not write.
- rEmpty  output  1  no committed tile available to read.
- errOvf  output  1  sticky: tileDone arrived while wFull.
- errUnf  output  1  sticky: rRelease arrived while rEmpty.
- wTileCnt  output  16  committed-tile counter, wraps at 2^16.
- rTileCnt  output  16  released-tile counter, wraps at 2^16.

Behaviour:
- State registers:
  - wPtr (1b): write half.
  - rPtr (1b): read half.
  - cnt (2b, 0..2): committed tiles.
  - The error flags and the two tile counters.
- Reset (async, rst=1): wPtr=0, rPtr=0, cnt=0, rData=0, errOvf=0, errUnf=0, wTileCnt=0, rTileCnt=0.
  - Outputs after reset: wFull=0, rEmpty=1.
  - RAM contents are not reset.
  - Asserting reset mid-tile discards all tiles.
- Status is combinational from registers: wFull = (cnt==2); rEmpty = (cnt==0).
- Physical address:
  - Write side uses {wPtr, wAddr[b]}; read side uses {rPtr, rAddr[b]}.
  - Each bank RAM is 2*OBufDepth deep.
- Write: for bank b with wEn[b]=1 and wFull=0, RAM[b][{wPtr,wAddr[b]}] <= wData[b] at the clock edge. Writes while wFull=1 are dropped silently.
- Read:
  - For bank b with rEn[b]=1, rData[b] <= RAM[b][{rPtr,rAddr[b]}] on the next edge.
  - Banks with rEn[b]=0 hold their previous rData[b].
  - Reads while rEmpty=1 are still performed (contents undefined); the reader is responsible for gating.
- Collision: when wPtr==rPtr, a same-cycle same-address read and write return the old data (read-first).
- Token update, evaluated each cycle with commit = tileDone & ~wFull and release = rRelease & ~rEmpty:
  - commit only: wPtr flips, cnt+1, wTileCnt+1.
  - release only: rPtr flips, cnt-1, rTileCnt+1.
  - both: wPtr and rPtr both flip, cnt unchanged, both counters +1.
  - Release while cnt==2 together with tileDone is legal, because commit is evaluated against the pre-cycle wFull. In that case the tileDone is rejected and flagged.
- Errors:
  - tileDone & wFull sets errOvf; the tileDone is ignored.
  - rRelease & rEmpty sets errUnf; the rRelease is ignored.
  - Both flags clear only on reset.
- Latency:
  - Write-to-visible: a tile committed at edge N is readable (rEmpty=0) from cycle N+1.
  - Read latency is 1 cycle.
  - wFull and rEmpty reflect a commit or release one cycle after the pulse.

Decomposition:
- Common package holds OBufBank, OBufDepth, OBufWidth, OBufAddrW, and a typedef obuf_half_t (logic [1:0] cnt encoding).
- Sub-module obuf_bank_ram: simple dual-port, read-first, 1-cycle registered read, one write port and one read port, depth 2*OBufDepth.
  - Generated OBufBank times.
  - The read-data register is async-reset to 0 inside the sub-module.

Test Plan:
- Reset check: assert rst mid-simulation -> immediately wFull=0, rEmpty=1, rData=0, both counters 0, both error flags 0.
- Single tile: write bank0 addr 5 = 0xA5 then tileDone -> next cycle rEmpty=0, wTileCnt=1; read bank0 addr 5 -> rData[0]=0xA5 one cycle later; rRelease -> rEmpty=1, rTileCnt=1.
- Fill to full: commit 2 tiles without release -> wFull=1; write 0xFF to addr 5 in all banks -> dropped, so tile 0 still reads its original data; third tileDone -> errOvf=1, cnt stays 2.
- Simultaneous: with cnt=1, pulse tileDone and rRelease together -> cnt=1, wPtr and rPtr both flip, both counters +1; the newly committed tile's data reads back correctly.
- Underflow: rRelease with cnt=0 -> errUnf=1, rPtr unchanged, rTileCnt unchanged.
- Collision: with wPtr==rPtr at cnt=0, write 0x11 and read the same address in the same cycle, where the old value was 0x22 -> rData=0x22; a read on the next cycle returns 0x11.

Source files
------------

// File: rtl/obuf_pingpong_pkg.sv
// Shared sizing for the ping-pong output buffer.
//   OBufBank  : number of independent banks
//   OBufDepth : entries per bank per half
//   OBufWidth : bits per entry
//   OBufAddrW : per-half address width (derived from OBufDepth)
//   obuf_half_t : encoding of the committed-tile count (0, 1 or 2)
package obuf_pingpong_pkg;
  localparam int OBufBank  = 4;
  localparam int OBufDepth = 64;
  localparam int OBufWidth = 128;
  localparam int OBufAddrW = $clog2(OBufDepth);

  typedef logic [1:0] obuf_half_t;

  localparam obuf_half_t HalfNone = 2'd0;
  localparam obuf_half_t HalfOne  = 2'd1;
  localparam obuf_half_t HalfBoth = 2'd2;
endpackage

// File: rtl/obuf_pingpong_bank_ram.sv
// One bank of the output buffer: simple dual-port RAM holding both halves.
// Ports:
//   clk, rst     : clock (rising edge), async active-high reset of rData only
//   wEn/wAddr/wData : write port, physical address {half, entry}
//   rEn/rAddr    : read port, physical address {half, entry}
//   rData        : registered read data, 1-cycle latency, held when rEn=0
// A same-address read and write in one cycle returns the old contents
// (read-first), which falls out of both ports sampling mem at the same edge.
module obuf_bank_ram #(
  parameter int Width = 128,
  parameter int AddrW = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wEn,
  input  logic [AddrW-1:0] wAddr,
  input  logic [Width-1:0] wData,
  input  logic             rEn,
  input  logic [AddrW-1:0] rAddr,
  output logic [Width-1:0] rData
);
  logic [Width-1:0] mem [2**AddrW];

  // Storage is deliberately not reset.
  always_ff @(posedge clk) begin
    if (wEn) mem[wAddr] <= wData;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      rData <= '0;
    else if (rEn) rData <= mem[rAddr];
  end
endmodule

// File: rtl/obuf_pingpong.sv
// Banked, double-buffered output buffer between the matrix array and the
// vector-stage reader.
// Ports:
//   clk, rst          : clock (rising edge), async active-high reset
//   wAddr/wData/wEn   : per-bank write port into the current write half
//   tileDone          : pulse, commits the write half
//   rAddr/rEn         : per-bank read port into the current read half
//   rRelease          : pulse, frees the read half
//   rData             : per-bank read data, 1-cycle latency
//   wFull / rEmpty    : both halves committed / nothing committed
//   errOvf / errUnf   : sticky, tileDone while full / rRelease while empty
//   wTileCnt/rTileCnt : wrapping committed / released tile counters
//
// Token handshake: a tileDone pulse is accepted only when wFull is low in
// that cycle, and an rRelease pulse only when rEmpty is low; both are judged
// against the registered status, so release-at-full plus tileDone frees a
// half but still rejects (and flags) the tileDone. Rejected pulses change
// nothing except the matching sticky error flag.
module obuf_pingpong
  import obuf_pingpong_pkg::*;
(
  input  logic                                clk,
  input  logic                                rst,
  input  logic [OBufBank-1:0][OBufAddrW-1:0]  wAddr,
  input  logic [OBufBank-1:0][OBufWidth-1:0]  wData,
  input  logic [OBufBank-1:0]                 wEn,
  input  logic                                tileDone,
  input  logic [OBufBank-1:0][OBufAddrW-1:0]  rAddr,
  input  logic [OBufBank-1:0]                 rEn,
  input  logic                                rRelease,
  output logic [OBufBank-1:0][OBufWidth-1:0]  rData,
  output logic                                wFull,
  output logic                                rEmpty,
  output logic                                errOvf,
  output logic                                errUnf,
  output logic [15:0]                         wTileCnt,
  output logic [15:0]                         rTileCnt
);
  logic       wPtr;
  logic       rPtr;
  obuf_half_t cnt;
  logic       commit;
  logic       release_;

  assign wFull    = (cnt == HalfBoth);
  assign rEmpty   = (cnt == HalfNone);
  assign commit   = tileDone & ~wFull;
  assign release_ = rRelease & ~rEmpty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wPtr     <= 1'b0;
      rPtr     <= 1'b0;
      cnt      <= HalfNone;
      errOvf   <= 1'b0;
      errUnf   <= 1'b0;
      wTileCnt <= 16'd0;
      rTileCnt <= 16'd0;
    end else begin
      if (commit) begin
        wPtr     <= ~wPtr;
        wTileCnt <= wTileCnt + 16'd1;
      end
      if (release_) begin
        rPtr     <= ~rPtr;
        rTileCnt <= rTileCnt + 16'd1;
      end
      // Simultaneous commit and release leave the count unchanged.
      if (commit && !release_)      cnt <= cnt + 2'd1;
      else if (release_ && !commit) cnt <= cnt - 2'd1;
      if (tileDone && wFull)  errOvf <= 1'b1;
      if (rRelease && rEmpty) errUnf <= 1'b1;
    end
  end

  for (genvar b = 0; b < OBufBank; b++) begin : gBank
    obuf_bank_ram #(
      .Width (OBufWidth),
      .AddrW (OBufAddrW + 1)
    ) uRam (
      .clk   (clk),
      .rst   (rst),
      .wEn   (wEn[b] & ~wFull),
      .wAddr ({wPtr, wAddr[b]}),
      .wData (wData[b]),
      .rEn   (rEn[b]),
      .rAddr ({rPtr, rAddr[b]}),
      .rData (rData[b])
    );
  end
endmodule

// File: tb/tb_obuf_pingpong.sv
module tb_obuf_pingpong;
  import obuf_pingpong_pkg::*;

  logic                               clk;
  logic                               rst;
  logic [OBufBank-1:0][OBufAddrW-1:0] wAddr;
  logic [OBufBank-1:0][OBufWidth-1:0] wData;
  logic [OBufBank-1:0]                wEn;
  logic                               tileDone;
  logic [OBufBank-1:0][OBufAddrW-1:0] rAddr;
  logic [OBufBank-1:0]                rEn;
  logic                               rRelease;
  logic [OBufBank-1:0][OBufWidth-1:0] rData;
  logic                               wFull;
  logic                               rEmpty;
  logic                               errOvf;
  logic                               errUnf;
  logic [15:0]                        wTileCnt;
  logic [15:0]                        rTileCnt;

  obuf_pingpong dut (
    .clk      (clk),
    .rst      (rst),
    .wAddr    (wAddr),
    .wData    (wData),
    .wEn      (wEn),
    .tileDone (tileDone),
    .rAddr    (rAddr),
    .rEn      (rEn),
    .rRelease (rRelease),
    .rData    (rData),
    .wFull    (wFull),
    .rEmpty   (rEmpty),
    .errOvf   (errOvf),
    .errUnf   (errUnf),
    .wTileCnt (wTileCnt),
    .rTileCnt (rTileCnt)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  int testsRun = 0;
  int testsFailed = 0;
  logic [OBufWidth-1:0] exp_q[$];

  task automatic check(input string tag, input logic [OBufWidth-1:0] obs,
                       input logic [OBufWidth-1:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change #1 after a rising edge; outputs are sampled at that point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idleInputs();
    wAddr = '0; wData = '0; wEn = '0; tileDone = 1'b0;
    rAddr = '0; rEn = '0; rRelease = 1'b0;
  endtask

  task automatic wr(input int b, input logic [OBufAddrW-1:0] a,
                    input logic [OBufWidth-1:0] d);
    wEn[b] = 1'b1; wAddr[b] = a; wData[b] = d;
    tick();
    wEn = '0;
  endtask

  task automatic wrAll(input logic [OBufAddrW-1:0] a, input logic [OBufWidth-1:0] base);
    for (int b = 0; b < OBufBank; b++) begin
      wEn[b] = 1'b1; wAddr[b] = a; wData[b] = base + OBufWidth'(b);
    end
    tick();
    wEn = '0;
  endtask

  task automatic pulse(input logic td, input logic rr);
    tileDone = td; rRelease = rr;
    tick();
    tileDone = 1'b0; rRelease = 1'b0;
  endtask

  task automatic rdAll(input string tag, input logic [OBufAddrW-1:0] a,
                       input logic [OBufWidth-1:0] base);
    logic [OBufWidth-1:0] e;
    for (int b = 0; b < OBufBank; b++) begin
      rEn[b] = 1'b1; rAddr[b] = a;
      exp_q.push_back(base + OBufWidth'(b));
    end
    tick();
    rEn = '0;
    for (int b = 0; b < OBufBank; b++) begin
      e = exp_q.pop_front();
      check($sformatf("%s bank%0d", tag, b), rData[b], e);
    end
  endtask

  task automatic rdOne(input string tag, input int b, input logic [OBufAddrW-1:0] a,
                       input logic [OBufWidth-1:0] exp);
    rEn[b] = 1'b1; rAddr[b] = a;
    exp_q.push_back(exp);
    tick();
    rEn = '0;
    check(tag, rData[b], exp_q.pop_front());
  endtask

  task automatic checkStatus(input string tag, input logic full, input logic empty,
                             input logic [15:0] wc, input logic [15:0] rc);
    check({tag, " wFull"}, OBufWidth'(wFull), OBufWidth'(full));
    check({tag, " rEmpty"}, OBufWidth'(rEmpty), OBufWidth'(empty));
    check({tag, " wTileCnt"}, OBufWidth'(wTileCnt), OBufWidth'(wc));
    check({tag, " rTileCnt"}, OBufWidth'(rTileCnt), OBufWidth'(rc));
  endtask

  task automatic checkResetState(input string tag);
    checkStatus(tag, 1'b0, 1'b1, 16'd0, 16'd0);
    check({tag, " errOvf"}, OBufWidth'(errOvf), '0);
    check({tag, " errUnf"}, OBufWidth'(errUnf), '0);
    for (int b = 0; b < OBufBank; b++)
      check($sformatf("%s rData%0d", tag, b), rData[b], '0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    idleInputs();
    rst = 1'b1;
    #1;
    checkResetState("por");
    tick();
    tick();
    rst = 1'b0;

    // Single tile through half 0.
    wr(0, 6'd5, 128'hA5);
    pulse(1'b1, 1'b0);
    checkStatus("single commit", 1'b0, 1'b0, 16'd1, 16'd0);
    rdOne("single read", 0, 6'd5, 128'hA5);
    pulse(1'b0, 1'b1);
    checkStatus("single release", 1'b0, 1'b1, 16'd1, 16'd1);

    // Fill both halves (write half 1 then half 0), then try to overwrite.
    wrAll(6'd5, 128'h100);
    pulse(1'b1, 1'b0);
    wrAll(6'd5, 128'h200);
    pulse(1'b1, 1'b0);
    checkStatus("full", 1'b1, 1'b0, 16'd3, 16'd1);
    check("full errOvf before", OBufWidth'(errOvf), '0);
    wrAll(6'd5, 128'hFF);
    rdAll("dropped write", 6'd5, 128'h100);
    pulse(1'b1, 1'b0);
    check("ovf errOvf", OBufWidth'(errOvf), 128'd1);
    checkStatus("ovf", 1'b1, 1'b0, 16'd3, 16'd1);

    // Release at full together with tileDone: release taken, commit rejected.
    pulse(1'b1, 1'b1);
    checkStatus("release at full", 1'b0, 1'b0, 16'd3, 16'd2);
    rdAll("second tile", 6'd5, 128'h200);

    // Simultaneous commit and release at cnt=1 (write half 1, read half 0).
    wrAll(6'd7, 128'h300);
    pulse(1'b1, 1'b1);
    checkStatus("simultaneous", 1'b0, 1'b0, 16'd4, 16'd3);
    rdAll("new tile", 6'd7, 128'h300);

    // Write pointer must now be on half 0: commit there and read it back.
    wr(2, 6'd9, 128'h4444);
    pulse(1'b1, 1'b0);
    checkStatus("after simul commit", 1'b1, 1'b0, 16'd5, 16'd3);
    pulse(1'b0, 1'b1);
    rdOne("half0 tile", 2, 6'd9, 128'h4444);
    pulse(1'b0, 1'b1);
    checkStatus("drained", 1'b0, 1'b1, 16'd5, 16'd5);
    check("errUnf before", OBufWidth'(errUnf), '0);

    // Underflow: ignored, flagged, read pointer stays on half 1.
    pulse(1'b0, 1'b1);
    check("unf errUnf", OBufWidth'(errUnf), 128'd1);
    checkStatus("unf", 1'b0, 1'b1, 16'd5, 16'd5);

    // Collision with wPtr==rPtr==1: read-first behaviour.
    wr(1, 6'd3, 128'h22);
    wEn[1] = 1'b1; wAddr[1] = 6'd3; wData[1] = 128'h11;
    rEn[1] = 1'b1; rAddr[1] = 6'd3;
    tick();
    wEn = '0; rEn = '0;
    check("collision old", rData[1], 128'h22);
    rdOne("collision new", 1, 6'd3, 128'h11);

    // Reset mid-run clears everything immediately.
    rst = 1'b1;
    #1;
    checkResetState("mid reset");
    tick();
    rst = 1'b0;
    tick();
    checkResetState("after reset");

    check("scoreboard drained", OBufWidth'(exp_q.size()), '0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end
endmodule
